// File: rtl/exec_wb_unit_pkg.sv
// rtl/exec_wb_unit_pkg.sv - shared opcodes, FSM states and register decode for exec_wb_unit
// Purpose: opcode constants, FSM state type and the one-hot destination
// decode used by the execute/write-back stage and its multiplier.
package exec_wb_unit_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MOV = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  // Register index to write-enable mask for the 4-entry register file.
  function automatic logic [3:0] dst_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/exec_wb_unit_seq_mul.sv
// rtl/exec_wb_unit_seq_mul.sv - iterative shift-add unsigned multiplier
// Purpose: DWIDTH-cycle shift-add multiply; one partial product per clock.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   start       load a/b and begin iterating (ignored while running)
//   a, b        multiplicand and multiplier
//   done        high during the final iteration (cnt == DWIDTH-1)
//   product     full 2*DWIDTH product, valid while done is high
module seq_mul #(
  parameter int DWIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DWIDTH-1:0]     a,
  input  logic [DWIDTH-1:0]     b,
  output logic                  done,
  output logic [2*DWIDTH-1:0]   product
);
  import exec_wb_unit_pkg::*;

  localparam int CW = $clog2(DWIDTH);
  localparam logic [CW-1:0] LAST = CW'(DWIDTH - 1);

  logic [2*DWIDTH-1:0] mcand;
  logic [DWIDTH-1:0]   mplier;
  logic [2*DWIDTH-1:0] acc;
  logic [2*DWIDTH-1:0] acc_next;
  logic [CW-1:0]       cnt;
  logic                active;

  assign acc_next = acc + (mplier[0] ? mcand : '0);
  // The product is taken from acc_next so the result lands on the same
  // edge as the last iteration rather than one cycle later.
  assign done     = active && (cnt == LAST);
  assign product  = acc_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (start && !active) begin
      mcand  <= {{DWIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
      active <= 1'b1;
    end else if (active) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (cnt == LAST) begin
        active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/exec_wb_unit.sv
// rtl/exec_wb_unit.sv - execute/write-back stage with single-cycle ALU and iterative MUL
// Purpose: captures operands on en_in, computes the ALU result (1 cycle) or
// a shift-add product (DWIDTH cycles), then drives the register-file write
// port, the completion pulse and the Z/C flags.
// Ports:
//   clk, rst_n        clock and synchronous active-low reset
//   en_in, op, dst    operand-valid pulse, opcode and destination index
//   rd_q, rs_q        operand A (destination value) and operand B
//   d_out, reg_en     write-back data and one-hot write enable (pulse)
//   en_out            op-complete pulse
//   busy              high while a MUL iterates; en_in is ignored then
//   flag_z, flag_c    zero and carry/borrow/overflow of the last completed op
module exec_wb_unit #(
  parameter int DWIDTH = 16,
  parameter int NREG   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_in,
  input  logic [2:0]        op,
  input  logic [1:0]        dst,
  input  logic [DWIDTH-1:0] rd_q,
  input  logic [DWIDTH-1:0] rs_q,
  output logic [DWIDTH-1:0] d_out,
  output logic [NREG-1:0]   reg_en,
  output logic              en_out,
  output logic              busy,
  output logic              flag_z,
  output logic              flag_c
);
  import exec_wb_unit_pkg::*;

  state_t              state;
  logic [1:0]          dst_q;
  logic                mul_start;
  logic                mul_done;
  logic [2*DWIDTH-1:0] mul_prod;
  logic [DWIDTH:0]     sum_w;
  logic [DWIDTH:0]     diff_w;
  logic [DWIDTH-1:0]   alu_res;
  logic                alu_c;

  assign mul_start = (state == ST_IDLE) && en_in && (op == OP_MUL);

  seq_mul #(.DWIDTH(DWIDTH)) u_seq_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (rd_q),
    .b       (rs_q),
    .done    (mul_done),
    .product (mul_prod)
  );

  // One extra bit on add/sub yields carry-out and borrow directly.
  assign sum_w  = {1'b0, rd_q} + {1'b0, rs_q};
  assign diff_w = {1'b0, rd_q} - {1'b0, rs_q};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum_w[DWIDTH-1:0];
        alu_c   = sum_w[DWIDTH];
      end
      OP_SUB, OP_CMP: begin
        alu_res = diff_w[DWIDTH-1:0];
        alu_c   = diff_w[DWIDTH];
      end
      OP_AND:  alu_res = rd_q & rs_q;
      OP_OR:   alu_res = rd_q | rs_q;
      OP_XOR:  alu_res = rd_q ^ rs_q;
      OP_MOV:  alu_res = rs_q;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      dst_q  <= '0;
      d_out  <= '0;
      reg_en <= '0;
      en_out <= 1'b0;
      busy   <= 1'b0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else begin
      reg_en <= '0;
      en_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en_in) begin
            if (op == OP_MUL) begin
              dst_q <= dst;
              busy  <= 1'b1;
              state <= ST_MUL;
            end else begin
              en_out <= 1'b1;
              flag_z <= (alu_res == '0);
              flag_c <= alu_c;
              // CMP only updates flags; d_out keeps its previous value.
              if (op != OP_CMP) begin
                d_out  <= alu_res;
                reg_en <= dst_onehot(dst);
              end
            end
          end
        end
        ST_MUL: begin
          // en_in is deliberately not looked at here, including on the
          // completion edge.
          if (mul_done) begin
            d_out  <= mul_prod[DWIDTH-1:0];
            reg_en <= dst_onehot(dst_q);
            en_out <= 1'b1;
            flag_z <= (mul_prod[DWIDTH-1:0] == '0);
            flag_c <= (mul_prod[2*DWIDTH-1:DWIDTH] != '0);
            busy   <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_wb_unit.sv
// tb/tb_exec_wb_unit.sv - self-checking bench for exec_wb_unit
module tb_exec_wb_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_in;
  logic [2:0]  op;
  logic [1:0]  dst;
  logic [15:0] rd_q;
  logic [15:0] rs_q;
  logic [15:0] d_out;
  logic [3:0]  reg_en;
  logic        en_out;
  logic        busy;
  logic        flag_z;
  logic        flag_c;

  int checks   = 0;
  int failures = 0;

  // Reference state: last written data and flags of the last completed op.
  logic [15:0] exp_d = 16'h0;
  logic        exp_z = 1'b0;
  logic        exp_c = 1'b0;

  exec_wb_unit #(.DWIDTH(16), .NREG(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_in  (en_in),
    .op     (op),
    .dst    (dst),
    .rd_q   (rd_q),
    .rs_q   (rs_q),
    .d_out  (d_out),
    .reg_en (reg_en),
    .en_out (en_out),
    .busy   (busy),
    .flag_z (flag_z),
    .flag_c (flag_c)
  );

  always #5 clk = ~clk;

  // Arithmetic reference straight from the opcode table.
  task automatic model(input int o, input int a, input int b,
                       output int res, output bit c, output bit wr);
    longint s;
    c   = 1'b0;
    wr  = (o != 7);
    res = 0;
    case (o)
      0: begin s = longint'(a) + longint'(b); res = int'(s % 65536); c = (s > 65535); end
      1, 7: begin res = (a - b + 65536) % 65536; c = (a < b); end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = b;
      6: begin s = longint'(a) * longint'(b); res = int'(s % 65536); c = (s >= 65536); end
      default: res = 0;
    endcase
  endtask

  // Drive one en_in pulse; afterwards scramble inputs so any late sampling shows.
  task automatic issue(input int o, input int d, input int a, input int b);
    @(negedge clk);
    en_in = 1'b1;
    op    = 3'(o);
    dst   = 2'(d);
    rd_q  = 16'(a);
    rs_q  = 16'(b);
    @(negedge clk);
    en_in = 1'b0;
    op    = 3'($urandom);
    dst   = 2'($urandom);
    rd_q  = 16'($urandom);
    rs_q  = 16'($urandom);
  endtask

  task automatic test_reset;
    issue(5, 1, 0, 16'hBEEF);
    @(negedge clk);
    rst_n = 1'b0;
    en_in = 1'b1;
    op    = 3'd0;
    rd_q  = 16'hFFFF;
    rs_q  = 16'h0001;
    @(negedge clk);
    @(negedge clk);
    en_in = 1'b0;
    checks++;
    if ({d_out, reg_en, en_out, busy, flag_z, flag_c} !== 24'h0) begin
      failures++;
      $display("FAIL reset: d_out=%h reg_en=%b en_out=%b busy=%b z=%b c=%b required all 0",
               d_out, reg_en, en_out, busy, flag_z, flag_c);
    end
    rst_n = 1'b1;
    exp_d = 0; exp_z = 0; exp_c = 0;
  endtask

  task automatic test_add_overflow;
    issue(0, 2, 16'hFFFF, 16'h0001);
    checks++;
    if ({d_out, reg_en, en_out, flag_z, flag_c} !== {16'h0000, 4'b0100, 1'b1, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL add_overflow: d_out=%h reg_en=%b en_out=%b z=%b c=%b required 0000 0100 1 1 1",
               d_out, reg_en, en_out, flag_z, flag_c);
    end
    @(negedge clk);
    checks++;
    if ({reg_en, en_out} !== 5'b0 || d_out !== 16'h0000) begin
      failures++;
      $display("FAIL add_pulse_clear: reg_en=%b en_out=%b d_out=%h required 0000 0 0000",
               reg_en, en_out, d_out);
    end
    exp_d = 16'h0000; exp_z = 1; exp_c = 1;
  endtask

  task automatic test_sub_cmp;
    issue(1, 1, 3, 5);
    checks++;
    if ({d_out, reg_en, en_out, flag_c} !== {16'hFFFE, 4'b0010, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL sub_borrow: d_out=%h reg_en=%b en_out=%b c=%b required fffe 0010 1 1",
               d_out, reg_en, en_out, flag_c);
    end
    issue(7, 3, 7, 7);
    checks++;
    if ({d_out, reg_en, en_out, flag_z, flag_c} !== {16'hFFFE, 4'b0000, 1'b1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL cmp_equal: d_out=%h reg_en=%b en_out=%b z=%b c=%b required fffe 0000 1 1 0",
               d_out, reg_en, en_out, flag_z, flag_c);
    end
    exp_d = 16'hFFFE; exp_z = 1; exp_c = 0;
  endtask

  task automatic test_mul;
    int n;
    int busy_cnt;
    issue(6, 3, 16'h0100, 16'h0101);
    n = 0; busy_cnt = 0;
    while (!en_out && n < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 16 || busy_cnt !== 16) begin
      failures++;
      $display("FAIL mul_latency: cycles=%0d busy_cycles=%0d required 16 16", n, busy_cnt);
    end
    checks++;
    if ({d_out, reg_en, en_out, flag_c, busy} !== {16'h0100, 4'b1000, 1'b1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL mul_overflow: d_out=%h reg_en=%b en_out=%b c=%b busy=%b required 0100 1000 1 1 0",
               d_out, reg_en, en_out, flag_c, busy);
    end
    // Second MUL with an en_in landing exactly on the completion edge.
    issue(6, 0, 12, 11);
    repeat (15) @(negedge clk);
    en_in = 1'b1; op = 3'd5; dst = 2'd2; rs_q = 16'h5555;
    @(negedge clk);
    en_in = 1'b0;
    checks++;
    if ({d_out, reg_en, en_out, flag_c} !== {16'd132, 4'b0001, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL mul_small: d_out=%0d reg_en=%b en_out=%b c=%b required 132 0001 1 0",
               d_out, reg_en, en_out, flag_c);
    end
    @(negedge clk);
    checks++;
    if ({reg_en, en_out, busy} !== 6'b0 || d_out !== 16'd132) begin
      failures++;
      $display("FAIL en_in_on_done: reg_en=%b en_out=%b busy=%b d_out=%0d required 0000 0 0 132",
               reg_en, en_out, busy, d_out);
    end
    exp_d = 16'd132; exp_z = 0; exp_c = 0;
  endtask

  task automatic test_en_in_busy;
    int pulses;
    issue(6, 2, 16'h00FF, 16'h0011);
    repeat (4) @(negedge clk);
    en_in = 1'b1; op = 3'd0; dst = 2'd1; rd_q = 16'h1111; rs_q = 16'h2222;
    @(negedge clk);
    en_in = 1'b0;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      if (en_out) begin
        pulses++;
        checks++;
        if (d_out !== 16'h10EF || reg_en !== 4'b0100) begin
          failures++;
          $display("FAIL busy_mul_result: d_out=%h reg_en=%b required 10ef 0100", d_out, reg_en);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (pulses !== 1) begin
      failures++;
      $display("FAIL busy_ignore: en_out pulses=%0d required 1", pulses);
    end
    exp_d = 16'h10EF; exp_z = 0; exp_c = 0;
  endtask

  task automatic test_reset_mid_mul;
    int pulses;
    issue(6, 1, 16'h0033, 16'h0044);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_d = 0; exp_z = 0; exp_c = 0;
    checks++;
    if (busy !== 1'b0 || d_out !== 16'h0) begin
      failures++;
      $display("FAIL reset_mid_mul: busy=%b d_out=%h required 0 0000", busy, d_out);
    end
    pulses = 0;
    for (int i = 0; i < 24; i++) begin
      if (en_out || reg_en != 4'b0) pulses++;
      @(negedge clk);
    end
    checks++;
    if (pulses !== 0) begin
      failures++;
      $display("FAIL abandoned_mul: write/complete pulses=%0d required 0", pulses);
    end
    issue(5, 0, 16'hAAAA, 16'h1234);
    checks++;
    if ({d_out, reg_en, en_out} !== {16'h1234, 4'b0001, 1'b1}) begin
      failures++;
      $display("FAIL mov_after_reset: d_out=%h reg_en=%b en_out=%b required 1234 0001 1",
               d_out, reg_en, en_out);
    end
    exp_d = 16'h1234; exp_z = 0; exp_c = 0;
  endtask

  task automatic test_back_to_back;
    int ops [3] = '{0, 4, 5};
    int as  [3];
    int bs  [3];
    int ds  [3];
    int res;
    bit c;
    bit wr;
    for (int i = 0; i < 3; i++) begin
      as[i] = int'($urandom_range(0, 65535));
      bs[i] = int'($urandom_range(0, 65535));
      ds[i] = int'($urandom_range(0, 3));
    end
    @(negedge clk);
    for (int i = 0; i <= 3; i++) begin
      if (i > 0) begin
        model(ops[i-1], as[i-1], bs[i-1], res, c, wr);
        checks++;
        if ({en_out, d_out, reg_en, flag_z, flag_c} !==
            {1'b1, 16'(res), 4'(1 << ds[i-1]), (res == 0), c}) begin
          failures++;
          $display("FAIL back_to_back[%0d]: en_out=%b d_out=%h reg_en=%b z=%b c=%b required 1 %h %b %b %b",
                   i-1, en_out, d_out, reg_en, flag_z, flag_c,
                   16'(res), 4'(1 << ds[i-1]), (res == 0), c);
        end
        exp_d = 16'(res); exp_z = (res == 0); exp_c = c;
      end
      if (i < 3) begin
        en_in = 1'b1; op = 3'(ops[i]); dst = 2'(ds[i]);
        rd_q = 16'(as[i]); rs_q = 16'(bs[i]);
      end else begin
        en_in = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random;
    int o, d, a, b, res, n, want_n;
    bit c;
    bit wr;
    for (int it = 0; it < 40; it++) begin
      o = int'($urandom_range(0, 7));
      d = int'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: a = 0;
        1: a = 65535;
        default: a = int'($urandom_range(0, 65535));
      endcase
      b = ($urandom_range(0, 3) == 0) ? a : int'($urandom_range(0, 65535));
      model(o, a, b, res, c, wr);
      issue(o, d, a, b);
      n = 0;
      while (!en_out && n < 40) begin
        @(negedge clk);
        n++;
      end
      want_n = (o == 6) ? 16 : 0;
      if (wr) exp_d = 16'(res);
      exp_z = (res == 0);
      exp_c = c;
      checks++;
      if (n !== want_n || d_out !== exp_d || reg_en !== (wr ? 4'(1 << d) : 4'b0) ||
          flag_z !== exp_z || flag_c !== exp_c) begin
        failures++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: wait=%0d d_out=%h reg_en=%b z=%b c=%b required wait=%0d %h %b %b %b",
                 it, o, a, b, n, d_out, reg_en, flag_z, flag_c,
                 want_n, exp_d, (wr ? 4'(1 << d) : 4'b0), exp_z, exp_c);
      end
      @(negedge clk);
      checks++;
      if (en_out !== 1'b0 || reg_en !== 4'b0 || d_out !== exp_d ||
          flag_z !== exp_z || flag_c !== exp_c || busy !== 1'b0) begin
        failures++;
        $display("FAIL random_hold[%0d]: en_out=%b reg_en=%b d_out=%h z=%b c=%b busy=%b required 0 0000 %h %b %b 0",
                 it, en_out, reg_en, d_out, flag_z, flag_c, busy, exp_d, exp_z, exp_c);
      end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    en_in = 1'b0;
    op    = 3'd0;
    dst   = 2'd0;
    rd_q  = 16'h0;
    rs_q  = 16'h0;
    test_reset();
    test_add_overflow();
    test_sub_cmp();
    test_mul();
    test_en_in_busy();
    test_reset_mid_mul();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
